multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multi-cycle FSM that sequences the CORG datapath around ControlUnit.
- Consumes the decoded control flags for the instruction in IR.
- Issues per-cycle strobes: instruction fetch, PC update, data-memory access, register-file write.
- Both memories use a req/ready handshake with a watchdog.
- Keeps a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)
WAIT_LIMIT, 255, max cycles req may stay high without ready before bus_error (1..2^16-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; start / keep executing
ctrl_reg_write  in  1  ControlUnit reg_write
ctrl_mem_read  in  1  ControlUnit mem_read
ctrl_mem_write  in  1  ControlUnit mem_write
ctrl_branch  in  1  ControlUnit branch
ctrl_jump  in  1  ControlUnit jump
ctrl_jump_reg  in  1  ControlUnit jump_reg
alu_zero  in  1  ALU zero flag (valid in EXEC)
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  00 PC+1, 01 branch target, 10 jump target, 11 register (jr)
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (qualifies dmem_req)
rf_we  out  1  register-file write strobe
retire  out  1  one-cycle pulse per completed instruction
retired_count  out  CNT_W  completed-instruction count
bus_error  out  1  sticky; watchdog expired
busy  out  1  state != IDLE

Behaviour:
- rst high: state=IDLE, all outputs 0, counters 0, bus_error cleared. Outputs are Moore-decoded from state, except the ready-qualified strobes below.
- IDLE: all strobes 0. If run=1 and bus_error=0 -> FETCH next edge.
- FETCH: imem_req=1.
  - imem_ready=1: ir_write=1, pc_write=1, pc_src=00 in the same cycle -> DECODE.
  - Otherwise stay in FETCH. imem_req stays high until ready.
- DECODE: 1 cycle, no strobes; ctrl_* settle from the new IR -> EXEC.
- EXEC branch priority: jump_reg > jump > branch > memory > reg_write.
  - jump_reg: pc_write=1, pc_src=11 -> retire.
  - jump: pc_write=1, pc_src=10 -> retire.
  - branch: pc_write=alu_zero, pc_src=01 -> retire.
  - mem_read or mem_write -> MEM. If both are set, read wins (dmem_we=0).
  - reg_write -> WB.
  - None of the above -> retire (NOP).
- MEM: dmem_req=1, dmem_we=ctrl_mem_write & ~ctrl_mem_read, both held until dmem_ready.
  - On dmem_ready: read -> WB; write -> retire.
- WB: rf_we=1 for exactly 1 cycle -> retire.
- Retire:
  - retire pulses in the completing cycle; retired_count+1 on that edge, wrapping to 0 from all-ones.
  - Next state is FETCH if run=1, else IDLE. run=0 mid-instruction never aborts the instruction.
- Latencies with zero-wait memories:
  - j/jr/beq: 3 cycles.
  - R-type/subi: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Watchdog:
  - Counter clears on entry to FETCH/MEM and increments each cycle req=1 and ready=0.
  - On reaching WAIT_LIMIT: bus_error=1, drop req, -> IDLE, no retire.
  - bus_error stays set until rst.
- ready asserted while the matching req=0 is ignored.
- rst asserted mid-handshake: req drops immediately (asynchronous); no strobe is produced.

Decomposition:
- Shared package corg_pkg:
  - state encoding constants S_IDLE..S_WB (3 bits).
  - PC_SRC_* constants.
  - the opcode constants already used by ControlUnit (JR=10101, SUBI=01010, BEQ=10010, LW=11010, J=00001).
- One natural sub-module: seq_watchdog (counter, clear, enable, limit compare, expired flag).

Test Plan:
- Reset then run=1, subi flags (reg_write=1, others 0), zero-wait memory:
  - imem_req rises 1 cycle after run.
  - rf_we pulses in cycle 4.
  - retired_count=1.
- beq flags: alu_zero=1 -> pc_write=1, pc_src=01 in EXEC; alu_zero=0 -> pc_write=0 in EXEC. Each retires in 3 cycles.
- lw with dmem_ready delayed 3 cycles: dmem_req/dmem_we=1/0 held 4 cycles, then WB rf_we=1, retire in 8 cycles. sw: dmem_we=1, no rf_we.
- jr and j back-to-back: pc_src=11 then 10. Priority check: jump_reg+branch both set -> pc_src=11 only.
- imem_ready held low with WAIT_LIMIT=8: bus_error=1 after 8 req cycles, state IDLE, run=1 does not restart until rst.
- run dropped during MEM of lw: instruction completes, retire pulses, enters IDLE, busy=0. CNT_W=2 run of 5 instructions: count reads 1.

Source files
------------

// File: rtl/corg_pkg.sv
// Shared CORG definitions: sequencer state encoding, PC source select codes and
// the ControlUnit opcodes.
package corg_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_PC1    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_SUBI = 5'b01010;
  localparam logic [4:0] OP_BEQ  = 5'b10010;
  localparam logic [4:0] OP_LW   = 5'b11010;
  localparam logic [4:0] OP_J    = 5'b00001;

endpackage

// File: rtl/seq_watchdog.sv
// Handshake watchdog: counts stalled request cycles and flags the cycle in which
// the stall budget runs out.
module seq_watchdog #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Fires during the WAIT_LIMIT-th stalled cycle so req is high exactly WAIT_LIMIT cycles.
  assign expired = enable && (count_q == 16'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the CORG datapath: walks FETCH/DECODE/EXEC/MEM/WB,
// issues the per-cycle strobes and counts retired instructions.
module multicycle_sequencer
  import corg_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             ctrl_reg_write,
  input  logic             ctrl_mem_read,
  input  logic             ctrl_mem_write,
  input  logic             ctrl_branch,
  input  logic             ctrl_jump,
  input  logic             ctrl_jump_reg,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             retire,
  output logic [CNT_W-1:0] retired_count,
  output logic             bus_error,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bus_error_q, bus_error_d;
  logic             wd_enable, wd_clear, wd_expired;

  // Count only stalled request cycles; any other cycle re-arms the watchdog.
  assign wd_enable = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM) && !dmem_ready);
  assign wd_clear  = !wd_enable;

  seq_watchdog #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bus_error_d = bus_error_q;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_PC1;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    retire      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run && !bus_error_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_PC1;
          state_d  = S_DECODE;
        end else if (wd_expired) begin
          bus_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (ctrl_jump_reg) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_REG;
          retire   = 1'b1;
        end else if (ctrl_jump) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          retire   = 1'b1;
        end else if (ctrl_branch) begin
          pc_write = alu_zero;
          pc_src   = PC_SRC_BRANCH;
          retire   = 1'b1;
        end else if (ctrl_mem_read || ctrl_mem_write) begin
          state_d = S_MEM;
        end else if (ctrl_reg_write) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_mem_write && !ctrl_mem_read;
        if (dmem_ready) begin
          if (ctrl_mem_read) state_d = S_WB;
          else               retire  = 1'b1;
        end else if (wd_expired) begin
          bus_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign retired_count = count_q;
  assign bus_error     = bus_error_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle output trace; a compare process checks it.
module tb_multicycle_sequencer;

  localparam int LIM = 8;

  typedef struct packed {
    logic run, rw, mr, mw, br, j, jr, z, ir, dr;
  } in_t;

  typedef struct packed {
    logic       imem_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       dmem_req, dmem_we, rf_we, retire, busy, bus_error;
    logic [1:0] count;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, ctrl_reg_write, ctrl_mem_read, ctrl_mem_write;
  logic       ctrl_branch, ctrl_jump, ctrl_jump_reg, alu_zero;
  logic       imem_ready, dmem_ready;
  logic       imem_req, ir_write, pc_write, dmem_req, dmem_we, rf_we, retire;
  logic [1:0] pc_src;
  logic [1:0] retired_count;
  logic       bus_error, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   m_count;
  bit   m_err;
  int   gen_len;
  in_t  gin_q[$];
  out_t gout_q[$];
  out_t chk_q[$];
  out_t exp_v, act_v;

  multicycle_sequencer #(
    .CNT_W     (2),
    .WAIT_LIMIT(LIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .ctrl_reg_write(ctrl_reg_write),
    .ctrl_mem_read (ctrl_mem_read),
    .ctrl_mem_write(ctrl_mem_write),
    .ctrl_branch   (ctrl_branch),
    .ctrl_jump     (ctrl_jump),
    .ctrl_jump_reg (ctrl_jump_reg),
    .alu_zero      (alu_zero),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .imem_req      (imem_req),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .rf_we         (rf_we),
    .retire        (retire),
    .retired_count (retired_count),
    .bus_error     (bus_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Per-cycle comparison against the model trace, away from the active edge.
  always @(negedge clk) begin
    if (chk_q.size() > 0) begin
      exp_v = chk_q.pop_front();
      act_v = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, rf_we,
               retire, busy, bus_error, retired_count};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL trace cycle %0d: got %b required %b", cyc, act_v, exp_v);
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  function automatic out_t base(input bit b);
    out_t o;
    o           = '0;
    o.busy      = b;
    o.bus_error = m_err;
    o.count     = m_count[1:0];
    return o;
  endfunction

  // Random filler for inputs the current step must ignore.
  function automatic in_t cyc_in(input logic [5:0] f, input bit z, input bit r);
    logic [9:0] v;
    in_t        i;
    v     = 10'($urandom);
    i     = v;
    i.jr  = f[5];
    i.j   = f[4];
    i.br  = f[3];
    i.mr  = f[2];
    i.mw  = f[1];
    i.rw  = f[0];
    i.z   = z;
    i.run = r;
    return i;
  endfunction

  task automatic emit(input in_t i, input out_t o);
    gin_q.push_back(i);
    gout_q.push_back(o);
    gen_len++;
  endtask

  task automatic emit_retire(input in_t i, input out_t o, input bit run_end);
    in_t  ii;
    out_t oo;
    ii        = i;
    oo        = o;
    ii.run    = run_end;
    oo.retire = 1'b1;
    emit(ii, oo);
    m_count = (m_count + 1) % 4;
  endtask

  task automatic gen_idle(input int n, input bit r);
    for (int k = 0; k < n; k++) emit(cyc_in(6'($urandom), 1'($urandom), r), base(1'b0));
  endtask

  // Flags f = {jump_reg, jump, branch, mem_read, mem_write, reg_write}.
  task automatic gen_instr(input logic [5:0] f, input int iw, input int dw, input bit z,
                           input bit run_mid, input bit run_end);
    in_t  i;
    out_t o;
    for (int w = 0; w < iw && w < LIM; w++) begin
      i = cyc_in(f, z, run_mid);
      i.ir = 1'b0;
      o = base(1'b1);
      o.imem_req = 1'b1;
      emit(i, o);
      if (w == LIM - 1) begin
        m_err = 1'b1;
        return;
      end
    end
    i = cyc_in(f, z, run_mid);
    i.ir = 1'b1;
    o = base(1'b1);
    o.imem_req = 1'b1;
    o.ir_write = 1'b1;
    o.pc_write = 1'b1;
    emit(i, o);
    emit(cyc_in(f, z, run_mid), base(1'b1));
    i = cyc_in(f, z, run_mid);
    o = base(1'b1);
    if (f[5]) begin
      o.pc_write = 1'b1;
      o.pc_src   = 2'b11;
      emit_retire(i, o, run_end);
      return;
    end
    if (f[4]) begin
      o.pc_write = 1'b1;
      o.pc_src   = 2'b10;
      emit_retire(i, o, run_end);
      return;
    end
    if (f[3]) begin
      o.pc_write = z;
      o.pc_src   = 2'b01;
      emit_retire(i, o, run_end);
      return;
    end
    if (!f[2] && !f[1] && !f[0]) begin
      emit_retire(i, o, run_end);
      return;
    end
    emit(i, o);
    if (f[2] || f[1]) begin
      for (int w = 0; w < dw && w < LIM; w++) begin
        i = cyc_in(f, z, run_mid);
        i.dr = 1'b0;
        o = base(1'b1);
        o.dmem_req = 1'b1;
        o.dmem_we  = f[1] & ~f[2];
        emit(i, o);
        if (w == LIM - 1) begin
          m_err = 1'b1;
          return;
        end
      end
      i = cyc_in(f, z, run_mid);
      i.dr = 1'b1;
      o = base(1'b1);
      o.dmem_req = 1'b1;
      o.dmem_we  = f[1] & ~f[2];
      if (!f[2]) begin
        emit_retire(i, o, run_end);
        return;
      end
      emit(i, o);
    end
    o = base(1'b1);
    o.rf_we = 1'b1;
    emit_retire(cyc_in(f, z, run_mid), o, run_end);
  endtask

  task automatic drive(input in_t i);
    run            = i.run;
    ctrl_reg_write = i.rw;
    ctrl_mem_read  = i.mr;
    ctrl_mem_write = i.mw;
    ctrl_branch    = i.br;
    ctrl_jump      = i.j;
    ctrl_jump_reg  = i.jr;
    alu_zero       = i.z;
    imem_ready     = i.ir;
    dmem_ready     = i.dr;
  endtask

  task automatic apply();
    while (gin_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(gin_q.pop_front());
      chk_q.push_back(gout_q.pop_front());
    end
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    #1;
    chk("bus_error_cleared_by_rst", 32'(bus_error), 32'd0);
    chk("count_cleared_by_rst", 32'(retired_count), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_err   = 1'b0;
    m_count = 0;
  endtask

  initial begin
    bit run_end;
    rst = 1'b1;
    drive('0);
    m_count = 0;
    m_err   = 1'b0;

    gen_idle(3, 1'b0);
    apply();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // subi from reset: fetch one cycle after run, rf_we in cycle 4
    gen_idle(1, 1'b1);
    gen_len = 0;
    gen_instr(6'b000001, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("len_subi", 32'(gen_len), 32'd4);
    apply();
    @(posedge clk);
    #1;
    chk("count_after_subi", 32'(retired_count), 32'd1);

    gen_idle(1, 1'b1);
    gen_len = 0;
    gen_instr(6'b001000, 0, 0, 1'b1, 1'b1, 1'b1);
    chk("len_beq_taken", 32'(gen_len), 32'd3);
    gen_len = 0;
    gen_instr(6'b001000, 0, 0, 1'b0, 1'b1, 1'b1);
    chk("len_beq_not_taken", 32'(gen_len), 32'd3);
    gen_len = 0;
    gen_instr(6'b000101, 0, 3, 1'b0, 1'b1, 1'b1);
    chk("len_lw_wait3", 32'(gen_len), 32'd8);
    gen_len = 0;
    gen_instr(6'b000010, 0, 0, 1'b0, 1'b1, 1'b1);
    chk("len_sw", 32'(gen_len), 32'd4);
    gen_instr(6'b100000, 0, 0, 1'b0, 1'b1, 1'b1);
    gen_instr(6'b010000, 0, 0, 1'b0, 1'b1, 1'b1);
    gen_len = 0;
    gen_instr(6'b101000, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("len_jr_plus_branch", 32'(gen_len), 32'd3);
    // run dropped throughout an lw: completes, then idles
    gen_idle(1, 1'b1);
    gen_instr(6'b000101, 1, 2, 1'b0, 1'b0, 1'b0);
    gen_idle(3, 1'b0);
    apply();

    gen_idle(1, 1'b1);
    for (int k = 0; k < 60; k++) begin
      run_end = (k == 59) ? 1'b0 : 1'($urandom);
      gen_instr(6'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                1'($urandom), 1'($urandom), run_end);
      if (!run_end && k != 59) begin
        gen_idle(int'($urandom_range(0, 2)), 1'b0);
        gen_idle(1, 1'b1);
      end
    end
    gen_idle(2, 1'b0);
    apply();

    // Fetch watchdog: req held LIM cycles, then sticky bus_error, no restart
    gen_idle(1, 1'b1);
    gen_instr(6'b000001, 20, 0, 1'b0, 1'b1, 1'b1);
    gen_idle(5, 1'b1);
    apply();
    @(posedge clk);
    #1;
    chk("bus_error_fetch_wd", 32'(bus_error), 32'd1);
    chk("busy_after_fetch_wd", 32'(busy), 32'd0);
    do_reset();

    // Data-side watchdog
    gen_idle(1, 1'b1);
    gen_instr(6'b000100, 0, 20, 1'b0, 1'b1, 1'b1);
    gen_idle(4, 1'b1);
    apply();
    @(posedge clk);
    #1;
    chk("bus_error_mem_wd", 32'(bus_error), 32'd1);
    do_reset();

    // Reset mid-handshake: req drops at once, no strobe even with ready high
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("imem_req_before_rst", 32'(imem_req), 32'd1);
    #2;
    imem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("imem_req_async_drop", 32'(imem_req), 32'd0);
    chk("no_ir_write_in_rst", 32'({ir_write, pc_write, busy}), 32'd0);
    imem_ready = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_count = 0;
    m_err   = 1'b0;

    // Five instructions with a 2-bit counter wraps to 1
    gen_idle(1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      gen_instr(6'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom), 1'b1, (k != 4));
    end
    apply();
    @(posedge clk);
    #1;
    chk("model_count_wrap", 32'(m_count), 32'd1);
    chk("count_wrap", 32'(retired_count), 32'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
